// File: rtl/edge_pkg.sv
// Shared types and helpers for the edge-map capture block.
package edge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    localparam int PACK_W = 8;

    function automatic int bytes_per_row(input int h);
        return (h + PACK_W - 1) / PACK_W;
    endfunction

endpackage

// File: rtl/edge_capture_packer.sv
// Packs a serial 1-bit pixel stream LSB-first into bytes; a flush closes a
// partial byte early, leaving its unused high bits at zero.
module edge_bit_packer
    import edge_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_bit,
    input  logic              i_valid,
    input  logic              i_flush,
    output logic [PACK_W-1:0] o_byte,
    output logic              o_byte_valid
);

    localparam int FILL_W = $clog2(PACK_W);

    logic [PACK_W-1:0] sr_q, sr_d, sr_next;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PACK_W-1:0] byte_q, byte_d;
    logic              byte_valid_q, byte_valid_d;
    logic              close;

    always_comb begin
        sr_d         = sr_q;
        fill_d       = fill_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        sr_next      = sr_q | (PACK_W'(i_valid & i_bit) << fill_q);
        close        = i_flush | (i_valid & (fill_q == FILL_W'(PACK_W - 1)));
        // The register is cleared after every byte, so padding is implicit.
        if (close && (i_valid || fill_q != '0)) begin
            byte_d       = sr_next;
            byte_valid_d = 1'b1;
            sr_d         = '0;
            fill_d       = '0;
        end else if (i_valid) begin
            sr_d   = sr_next;
            fill_d = fill_q + FILL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr_q         <= '0;
            fill_q       <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            fill_q       <= fill_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
        end
    end

    assign o_byte       = byte_q;
    assign o_byte_valid = byte_valid_q;

endmodule

// File: rtl/edge_capture.sv
// Binarizes the Sobel magnitude stream for preview and captures one frame,
// packed 1 bit per pixel, into the plotter bitmap RAM.
//   state   | meaning
//   IDLE    | no capture pending
//   ARMED   | request accepted, waiting for vsync rise
//   CAPTURE | packing pixels of the current frame
//   DONE    | capture finished, frame-done pulse follows
module edge_capture
    import edge_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int H_RES  = 172,
    parameter int V_RES  = 240,
    parameter int ADDR_W = $clog2(V_RES * ((H_RES + 7) / 8))
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               i_vsync,
    input  logic                               i_hsync,
    input  logic                               i_de,
    input  logic [WIDTH-1:0]                   i_data,
    input  logic [WIDTH-1:0]                   i_threshold,
    input  logic                               i_capture,
    output logic                               o_vsync,
    output logic                               o_hsync,
    output logic                               o_de,
    output logic [WIDTH-1:0]                   o_data,
    output logic                               o_wr_en,
    output logic [ADDR_W-1:0]                  o_wr_addr,
    output logic [PACK_W-1:0]                  o_wr_data,
    output logic                               o_busy,
    output logic                               o_frame_done,
    output logic                               o_frame_err,
    output logic [$clog2(H_RES*V_RES+1)-1:0]   o_edge_count
);

    localparam int CNT_W = $clog2(H_RES * V_RES + 1);
    localparam int COL_W = $clog2(H_RES);
    localparam int ROW_W = $clog2(V_RES);

    cap_state_t       state_q, state_d;
    logic             vsync_q, hsync_q, de_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] thr_lat_q, thr_lat_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic             vs_rise, cap_bit, de_cap, last_col, last_row, short_frame;
    logic             pk_flush, pk_valid;
    logic [PACK_W-1:0] pk_byte;

    always_comb begin
        vs_rise     = i_vsync & ~vsync_q;
        cap_bit     = (i_data >= thr_lat_q);
        // A pixel coincident with the next frame's vsync rise belongs to that frame.
        de_cap      = (state_q == CAPTURE) & i_de & ~vs_rise;
        last_col    = (col_q == COL_W'(H_RES - 1));
        last_row    = (row_q == ROW_W'(V_RES - 1));
        short_frame = (state_q == CAPTURE) & vs_rise;
        pk_flush    = (de_cap & last_col) | short_frame;
        data_d      = (i_data >= i_threshold) ? '1 : '0;
        done_d      = (state_q == DONE);
    end

    always_comb begin
        state_d   = state_q;
        thr_lat_d = thr_lat_q;
        col_d     = col_q;
        row_d     = row_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        if (pk_valid) begin
            addr_d = addr_q + ADDR_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (i_capture) begin
                    state_d = ARMED;
                    err_d   = 1'b0;
                end
            end
            ARMED: begin
                if (vs_rise) begin
                    state_d   = CAPTURE;
                    thr_lat_d = i_threshold;
                    col_d     = '0;
                    row_d     = '0;
                    addr_d    = '0;
                    cnt_d     = '0;
                end
            end
            CAPTURE: begin
                if (short_frame) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (de_cap) begin
                    cnt_d = cnt_q + CNT_W'(cap_bit);
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            state_d = DONE;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            vsync_q   <= 1'b0;
            hsync_q   <= 1'b0;
            de_q      <= 1'b0;
            data_q    <= '0;
            thr_lat_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vsync_q   <= i_vsync;
            hsync_q   <= i_hsync;
            de_q      <= i_de;
            data_q    <= data_d;
            thr_lat_q <= thr_lat_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    edge_bit_packer u_packer (
        .clk          (clk),
        .rstn         (rstn),
        .i_bit        (cap_bit),
        .i_valid      (de_cap),
        .i_flush      (pk_flush),
        .o_byte       (pk_byte),
        .o_byte_valid (pk_valid)
    );

    assign o_vsync      = vsync_q;
    assign o_hsync      = hsync_q;
    assign o_de         = de_q;
    assign o_data       = data_q;
    assign o_wr_en      = pk_valid;
    assign o_wr_addr    = addr_q;
    assign o_wr_data    = pk_byte;
    assign o_busy       = (state_q == ARMED) || (state_q == CAPTURE);
    assign o_frame_done = done_q;
    assign o_frame_err  = err_q;
    assign o_edge_count = cnt_q;

endmodule

// File: tb/tb_edge_capture.sv
// Randomized bench for edge_capture: a pixel-list model predicts the bitmap
// bytes, edge count, done timing and passthrough outputs.
module tb_edge_capture;

    localparam int WIDTH  = 8;
    localparam int H_RES  = 172;
    localparam int V_RES  = 240;
    localparam int BPR    = (H_RES + 7) / 8;
    localparam int ADDR_W = $clog2(V_RES * BPR);
    localparam int CNT_W  = $clog2(H_RES * V_RES + 1);

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic i_vsync, i_hsync, i_de, i_capture;
    logic [WIDTH-1:0] i_data, i_threshold;
    logic o_vsync, o_hsync, o_de, o_wr_en, o_busy, o_frame_done, o_frame_err;
    logic [WIDTH-1:0] o_data;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [7:0] o_wr_data;
    logic [CNT_W-1:0] o_edge_count;

    edge_capture #(.WIDTH(WIDTH), .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rstn(rstn),
        .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de), .i_data(i_data),
        .i_threshold(i_threshold), .i_capture(i_capture),
        .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de), .o_data(o_data),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_frame_err(o_frame_err),
        .o_edge_count(o_edge_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: write log, done pulses and passthrough against last cycle's inputs.
    logic [ADDR_W-1:0] wa_q[$];
    logic [7:0]        wd_q[$];
    int                done_cnt = 0;
    int                done_cyc = -1;
    logic [CNT_W-1:0]  done_edges = '0;
    logic              pt_ok = 1'b0;
    logic [10:0]       pt_exp;

    always @(negedge clk) begin
        if (!rstn) begin
            pt_ok = 1'b0;
        end else begin
            if (pt_ok) chk("passthru", {o_vsync, o_hsync, o_de, o_data}, pt_exp);
            pt_exp = {i_vsync, i_hsync, i_de, (i_data >= i_threshold) ? 8'hFF : 8'h00};
            pt_ok  = 1'b1;
            if (o_wr_en) begin
                wa_q.push_back(o_wr_addr);
                wd_q.push_back(o_wr_data);
            end
            if (o_frame_done) begin
                done_cnt++;
                done_cyc   = cyc;
                done_edges = o_edge_count;
            end
        end
    end

    // Reference model: the captured pixels in raster order plus the latched threshold.
    logic [7:0] pix_q[$];
    logic [7:0] thr_cap;
    int         vs_cyc, last_cyc;

    function automatic logic [7:0] exp_byte(input int a);
        int r = a / BPR;
        int k = a % BPR;
        logic [7:0] b = 8'h00;
        for (int j = 0; j < 8; j++) begin
            int c   = k * 8 + j;
            int idx = r * H_RES + c;
            if (c < H_RES && idx < pix_q.size()) b[j] = (pix_q[idx] >= thr_cap);
        end
        return b;
    endfunction

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        pix_q.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic tick(input logic vs, input logic hs, input logic de,
                        input logic [7:0] d, input logic cap);
        @(posedge clk);
        #1;
        i_vsync   = vs;
        i_hsync   = hs;
        i_de      = de;
        i_data    = d;
        i_capture = cap;
    endtask

    task automatic send_frame(input int npix, input bit rec, input int chg_at,
                              input logic [7:0] chg_thr, input int cap_at);
        tick(1, 0, 0, 8'h00, 0);
        vs_cyc = cyc;
        if (rec) thr_cap = i_threshold;
        tick(1, 0, 0, 8'h00, 0);
        tick(1, 0, 0, 8'h00, 0);
        tick(0, 0, 0, 8'h00, 0);
        tick(0, 0, 0, 8'h00, 0);
        for (int i = 0; i < npix; i++) begin
            logic [7:0] d;
            case ($urandom_range(0, 3))
                0:       d = i_threshold - 8'd1;
                1:       d = i_threshold;
                2:       d = i_threshold + 8'd1;
                default: d = 8'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) tick(0, 1'($urandom), 0, 8'($urandom), 0);
            tick(0, 1'($urandom), 1, d, i == cap_at);
            if (i == chg_at) i_threshold = chg_thr;
            if (rec) pix_q.push_back(d);
            last_cyc = cyc;
        end
        tick(0, 0, 0, 8'h00, 0);
    endtask

    task automatic verify(input string tag, input bit full);
        int n     = pix_q.size();
        int nb    = (n / H_RES) * BPR + ((n % H_RES) + 7) / 8;
        int edges = 0;
        foreach (pix_q[i]) if (pix_q[i] >= thr_cap) edges++;
        chk({tag, "_nwr"}, wa_q.size(), nb);
        for (int i = 0; i < wa_q.size() && i < nb; i++) begin
            chk({tag, "_addr"}, wa_q[i], i);
            chk({tag, "_data"}, wd_q[i], exp_byte(i));
        end
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_edges"}, done_edges, edges);
        chk({tag, "_err"}, o_frame_err, !full);
        chk({tag, "_busy"}, o_busy, 0);
    endtask

    function automatic logic [63:0] all_outs();
        return {o_vsync, o_hsync, o_de, o_data, o_wr_en, o_wr_addr, o_wr_data,
                o_busy, o_frame_done, o_frame_err, o_edge_count};
    endfunction

    initial begin
        i_vsync = 0; i_hsync = 0; i_de = 0; i_data = 0; i_threshold = 0; i_capture = 0;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outs", all_outs(), 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) tick(0, 0, 0, 8'h00, 0);

        // Full frame, random threshold, threshold changed mid-capture.
        i_threshold = 8'($urandom_range(1, 254));
        clear_log();
        tick(0, 0, 0, 8'h00, 1);
        tick(0, 0, 0, 8'h00, 0);
        chk("A_armed_busy", o_busy, 1);
        send_frame(H_RES * V_RES, 1, 2000, ~i_threshold, -1);
        repeat (4) tick(0, 0, 0, 8'h00, 0);
        chk("A_done_cyc", done_cyc, last_cyc + 2);
        verify("A", 1);

        // Short frame with threshold 0: 10 rows + 5 pixels, ended by next vsync.
        i_threshold = 8'd0;
        clear_log();
        tick(0, 0, 0, 8'h00, 1);
        send_frame(10 * H_RES + 5, 1, -1, 8'h00, -1);
        send_frame(0, 0, -1, 8'h00, -1);
        repeat (3) tick(0, 0, 0, 8'h00, 0);
        chk("B_done_cyc", done_cyc, vs_cyc + 2);
        chk("B_last_addr", (wa_q.size() > 0) ? wa_q[wa_q.size()-1] : 0, 220);
        chk("B_last_byte", (wd_q.size() > 0) ? wd_q[wd_q.size()-1] : 0, 8'h1F);
        verify("B", 0);
        clear_log();
        send_frame(50, 0, -1, 8'h00, -1);
        chk("B_no_rearm_wr", wa_q.size(), 0);
        chk("B_no_rearm_busy", o_busy, 0);

        // Capture requested mid-frame: nothing until the next vsync rise.
        i_threshold = 8'($urandom_range(0, 255));
        clear_log();
        send_frame(400, 0, -1, 8'h00, 150);
        chk("C_armed_busy", o_busy, 1);
        chk("C_no_wr", wa_q.size(), 0);
        clear_log();
        send_frame(2 * H_RES + 20, 1, -1, 8'h00, -1);
        send_frame(0, 0, -1, 8'h00, -1);
        repeat (3) tick(0, 0, 0, 8'h00, 0);
        verify("C", 0);

        // Accepted capture clears the sticky error.
        tick(0, 0, 0, 8'h00, 1);
        tick(0, 0, 0, 8'h00, 0);
        chk("err_clear", o_frame_err, 0);
        chk("err_clear_busy", o_busy, 1);

        // Reset in the middle of a capture.
        clear_log();
        send_frame(300, 0, -1, 8'h00, -1);
        chk("R_capturing", o_busy, 1);
        #2 rstn = 1'b0;
        #1;
        chk("R_async_outs", all_outs(), 64'd0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (5) tick(0, 0, 0, 8'h00, 0);
        chk("R_no_done", done_cnt, 0);
        chk("R_idle_busy", o_busy, 0);

        i_threshold = 8'($urandom_range(0, 255));
        clear_log();
        tick(0, 0, 0, 8'h00, 1);
        send_frame(3 * H_RES + 9, 1, -1, 8'h00, -1);
        send_frame(0, 0, -1, 8'h00, -1);
        repeat (3) tick(0, 0, 0, 8'h00, 0);
        verify("R", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_capture.md
# edge_capture

Downstream consumer of the Sobel stage. Binarizes the 8-bit edge-magnitude video stream against a programmable threshold and packs one captured frame into 1-bit-per-pixel bytes for the plotter bitmap RAM. Also forwards the binarized stream, with its syncs, for the preview display. Capture is one-shot per request and frame-aligned on vsync.

## Interface
- `WIDTH`, 8: pixel magnitude width.
- `H_RES`, 172: active pixels per line.
- `V_RES`, 240: active lines per frame.
- `ADDR_W`, `$clog2(V_RES*((H_RES+7)/8))`: write address width.
- `clk` input 1: pixel clock; sole clock.
- `rstn` input 1: reset, asynchronous, active-low.
- `i_vsync`, `i_hsync`, `i_de` input 1 each: sync and data enable from Sobel. Active-high.
- `i_data` input WIDTH: edge magnitude.
- `i_threshold` input WIDTH: binarization threshold, quasi-static.
- `i_capture` input 1: single-cycle request to capture the next full frame.
- `o_vsync`, `o_hsync`, `o_de` output 1 each: inputs delayed by 1 cycle.
- `o_data` output WIDTH: all-ones if edge, else 0. Delayed 1 cycle.
- `o_wr_en` output 1: bitmap RAM write strobe.
- `o_wr_addr` output ADDR_W: byte address.
- `o_wr_data` output 8: packed pixels.
- `o_busy` output 1: high in ARMED or CAPTURE.
- `o_frame_done` output 1: one-cycle pulse at capture end.
- `o_frame_err` output 1: sticky; set on short frame, cleared on accepted `i_capture`.
- `o_edge_count` output `$clog2(H_RES*V_RES+1)`: edge pixels in the last capture.

## Operation
- Edge bit is `i_data >= thr`.
  - Preview path uses live `i_threshold`.
  - Capture path uses `thr_lat`, latched at frame start.
  - Threshold 0 makes every pixel an edge.
- Frame start is the rising edge of `i_vsync`, detected against a registered copy.
- States:
  - **IDLE**: `i_capture` moves to ARMED and clears `o_frame_err`.
  - **ARMED**: waits for frame start. On frame start, latch `thr_lat`, zero column, row, address and edge counters, then go to CAPTURE.
  - **CAPTURE**: every `i_de` cycle shifts the edge bit into the pack register.
    - The first pixel of each byte goes to bit 0, LSB first.
    - Column increments. Edge counter increments when the bit is 1.
  - **DONE**: one cycle; pulses `o_frame_done`, then returns to IDLE.
- Byte write occurs when 8 bits are collected or on the last column (`H_RES-1`).
  - Rows never share a byte.
  - A partial last byte is zero-padded in its high bits. For 172 px that is 22 bytes/row, last byte bits[7:4]=0.
  - Address increments after each write.
  - Address = row*((H_RES+7)/8) + col/8.
- End of capture:
  - Last pixel of row `V_RES-1` → DONE.
  - A frame-start edge while in CAPTURE is a short frame:
    - flush any partial byte;
    - set `o_frame_err`;
    - go to DONE;
    - do not re-arm on that edge.
- `i_capture` is ignored while `o_busy`=1 or in DONE.
- `i_hsync` is used only for passthrough. Line structure comes from `i_de` counts.

## Timing
- Passthrough latency is exactly 1 cycle for syncs, `o_de` and `o_data`.
  - `o_data` updates every cycle; it is not gated by `i_de`.
- `o_wr_en` is high for 1 cycle, in the cycle after the `i_de` cycle that completes a byte. Address and data are valid in that same cycle.
- `o_frame_done` rises the cycle after the final `o_wr_en`, i.e. 2 cycles after the last pixel's `i_de`.
  - `o_edge_count` is final when `o_frame_done` is high. It holds until the next frame start in ARMED.
- Back-to-back `i_de` with no gaps is supported: one write per 8 pixels, no stall.
- Reset values: all outputs 0, state IDLE, all counters, `thr_lat` and pack register 0.
  - Reset mid-capture abandons the frame; no `o_frame_done`.

## Structure
- Package `edge_pkg`:
  - state enum `cap_state_t` {IDLE, ARMED, CAPTURE, DONE};
  - constant `PACK_W=8`;
  - function `bytes_per_row(h)`.
- Sub-module `edge_bit_packer`:
  - shift register plus 3-bit fill count;
  - inputs `bit`, `valid`, `flush`;
  - outputs `byte`, `byte_valid`.
- The top level holds the FSM, counters and passthrough.

## Test plan
- Threshold 100, stream `i_data` alternating 120/50, full 172×240 frame after `i_capture` → 5280 writes, full bytes 0x55, last byte per row 0x05, `o_edge_count`=20640, `o_frame_done` 2 cycles after last pixel.
- Threshold 0, all-zero data → every byte 0xFF except row-end bytes 0x0F, address runs 0..5279, count 41280.
- `i_capture` asserted mid-frame → no writes until the next vsync rise; capture then starts at address 0.
- Second vsync rise after 10 rows + 5 pixels → partial byte 0x1F written at address 220 (with all-edge data), `o_frame_err`=1, `o_frame_done` pulse; next accepted `i_capture` clears `o_frame_err`.
- Change `i_threshold` from 100 to 200 mid-capture → capture bits still use 100; `o_data` switches to 200 the next cycle.
- Deassert `rstn` mid-capture → all outputs 0 asynchronously, no `o_frame_done`; after release, `i_capture` starts a clean capture.
